// File: rtl/varray_ctrl_pkg.sv
// Shared types and defaults for the varray sequencing controller.
package varray_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Longest run a single varray write may carry (fits the 5-bit length port).
  localparam int MAX_CHUNK_DEFAULT = 31;

  typedef logic [4:0] chunk_len_t;

endpackage

// File: rtl/varray_rr_arb.sv
// Two-requester round-robin arbiter. A grant is only issued while grant_en
// is high; the requester not served most recently wins a tie.
module varray_rr_arb
  import varray_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  logic last_grant;

  // Pick one requester; on a tie favour the one not granted last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (grant_en) begin
      if (req0 && (!req1 || last_grant)) grant0 = 1'b1;
      else if (req1)                     grant1 = 1'b1;
    end
  end

  // Remember who was served; the reset value lets req0 win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= 1'b1;
    else if (grant0) last_grant <= 1'b0;
    else if (grant1) last_grant <= 1'b1;
  end

endmodule

// File: rtl/varray_ctrl.sv
// Owns the varray write/read port pair: arbitrates run-length fill requests,
// splits each run into chunks of at most MAX_CHUNK elements (never wrapping
// past the top address), and drains the array as a back-pressured stream.
module varray_ctrl
  import varray_ctrl_pkg::*;
#(
  parameter int VIRTUAL_ELEMENT_WIDTH = 4,
  parameter int VIRTUAL_ADDR_BITS     = 16,
  parameter int MAX_CHUNK             = MAX_CHUNK_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req0_valid,
  output logic                             req0_ready,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     req0_addr,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     req0_len,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] req0_dat,
  input  logic                             req1_valid,
  output logic                             req1_ready,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     req1_addr,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     req1_len,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] req1_dat,
  input  logic                             drain_start,
  output logic                             drain_busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] out_dat,
  output logic                             out_last,
  output logic                             wr_trunc,
  output logic                             va_we,
  output logic [VIRTUAL_ADDR_BITS-1:0]     va_write_addr,
  output logic [4:0]                       va_write_addr_len,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] va_dat_w,
  output logic                             va_re,
  output logic [VIRTUAL_ADDR_BITS-1:0]     va_read_addr,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] va_dat_r,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     va_len
);

  localparam int AW = VIRTUAL_ADDR_BITS;
  localparam int EW = VIRTUAL_ELEMENT_WIDTH;
  localparam logic [AW:0] CHUNK_MAX = (AW+1)'(MAX_CHUNK);
  localparam logic [AW:0] ADDR_TOP  = {1'b1, {AW{1'b0}}};

  state_t        state, state_nx;
  logic          drain_pend, drain_go;
  logic          grant_en, grant0, grant1, req_hs;
  logic [AW-1:0] req_addr, req_len;
  logic [EW-1:0] req_dat;
  logic [AW-1:0] wr_addr, wr_rem;
  logic [EW-1:0] wr_dat;
  logic [AW:0]   space, chunk;
  logic          chunk_done, chunk_clip;
  logic [AW-1:0] drain_len, rd_addr, beat_idx;
  logic          inflight, pop;
  logic [1:0]    buf_cnt;
  logic [EW-1:0] buf0, buf1, head;

  // A pending or freshly pulsed drain blocks new grants while idle.
  assign drain_go = drain_pend | drain_start;
  assign grant_en = reset && (state == ST_IDLE) && !drain_go;

  varray_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .grant_en (grant_en),
    .req0     (req0_valid),
    .req1     (req1_valid),
    .grant0   (grant0),
    .grant1   (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign req_hs     = grant0 | grant1;
  assign req_addr   = grant1 ? req1_addr : req0_addr;
  assign req_len    = grant1 ? req1_len  : req0_len;
  assign req_dat    = grant1 ? req1_dat  : req0_dat;

  // Chunk length is the smallest of remaining run, MAX_CHUNK and room left below the top.
  always_comb begin
    space = ADDR_TOP - {1'b0, wr_addr};
    chunk = {1'b0, wr_rem};
    if (chunk > CHUNK_MAX) chunk = CHUNK_MAX;
    if (chunk > space)     chunk = space;
    chunk_done = (chunk == {1'b0, wr_rem});
    chunk_clip = !chunk_done && (chunk == space);
  end

  assign va_we             = (state == ST_WRITE);
  assign va_write_addr     = va_we ? wr_addr : '0;
  assign va_write_addr_len = va_we ? chunk[4:0] : '0;
  assign va_dat_w          = va_we ? wr_dat : '0;
  assign wr_trunc          = va_we && chunk_clip;

  // Reads are issued while reads in flight plus buffered elements stay below two;
  // when the buffer is empty the arriving read data is presented directly.
  assign drain_busy   = (state == ST_DRAIN);
  assign va_re        = drain_busy && (rd_addr < drain_len) && (({1'b0, inflight} + buf_cnt) < 2'd2);
  assign va_read_addr = va_re ? rd_addr : '0;
  assign out_valid    = drain_busy && ((buf_cnt != 2'd0) || inflight);
  assign head         = (buf_cnt != 2'd0) ? buf0 : va_dat_r;
  assign out_dat      = out_valid ? head : '0;
  assign out_last     = out_valid && (beat_idx == drain_len - AW'(1));
  assign pop          = out_valid && out_ready;

  // Next-state selection for the idle/write/drain sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (drain_go)                     state_nx = ST_DRAIN;
        else if (req_hs && req_len != '0) state_nx = ST_WRITE;
      end
      ST_WRITE: if (chunk_done || chunk_clip)              state_nx = ST_IDLE;
      ST_DRAIN: if ((drain_len == '0) || (pop && out_last)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Control state: FSM, run bookkeeping, drain counters and buffer occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      drain_pend <= 1'b0;
      wr_addr    <= '0;
      wr_rem     <= '0;
      drain_len  <= '0;
      rd_addr    <= '0;
      beat_idx   <= '0;
      inflight   <= 1'b0;
      buf_cnt    <= '0;
    end else begin
      state    <= state_nx;
      inflight <= va_re;
      buf_cnt  <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
      case (state)
        ST_IDLE: begin
          if (drain_go) begin
            drain_pend <= 1'b0;
            drain_len  <= va_len;
            rd_addr    <= '0;
            beat_idx   <= '0;
          end else if (req_hs) begin
            wr_addr <= req_addr;
            wr_rem  <= req_len;
          end
        end
        ST_WRITE: begin
          if (drain_start) drain_pend <= 1'b1;
          wr_addr <= wr_addr + chunk[AW-1:0];
          wr_rem  <= wr_rem - chunk[AW-1:0];
        end
        ST_DRAIN: begin
          if (va_re) rd_addr  <= rd_addr + AW'(1);
          if (pop)   beat_idx <= beat_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Fill value of the accepted run.
  always_ff @(posedge clk) begin
    if (req_hs) wr_dat <= req_dat;
  end

  // Two-entry output buffer: buf0 is the head; read data is parked only when not consumed on arrival.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (buf_cnt == 2'd2) begin
        buf0 <= buf1;
        if (inflight) buf1 <= va_dat_r;
      end else if (buf_cnt == 2'd1 && inflight) begin
        buf0 <= va_dat_r;
      end
    end else if (inflight) begin
      if (buf_cnt == 2'd0) buf0 <= va_dat_r;
      else                 buf1 <= va_dat_r;
    end
  end

endmodule
